// File: rtl/cc3_bus_pkg.sv
// Shared CC3 bus definitions: arbiter FSM encoding, BIOS RAM window defaults and the window decode.
// Combinational helpers only. No handshake of their own.
// Used by the RAM arbiter, the CC3 top and the BIOS RAM wrapper.
package cc3_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_t;

  localparam int          CC3_MEM_AW   = 11;
  localparam logic [15:0] CC3_WIN_BASE = 16'hF800;
  localparam logic [7:0]  CC3_OPEN_BUS = 8'hFF;

  // 17-bit compare so a window ending at 16'hFFFF does not wrap.
  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base,
                                     input int aw);
    logic [16:0] top;
    top = {1'b0, base} + (17'd1 << aw) - 17'd1;
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= top);
  endfunction

endpackage

// File: rtl/cc3_rr_arb2.sv
// Two-way round-robin picker: one-hot grant from req, favouring the master that was not last served.
// Purely combinational, zero latency.
// No backpressure; grant is forced to zero while advance is low.
module cc3_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       advance,
  output logic [1:0] grant
);

  // last_grant: 0 = master 0 served last, 1 = master 1 served last.
  always_comb begin
    grant = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/cc3_mem_arbiter.sv
// Shares one BIOS RAM port between two CPU masters, round-robin, with open-bus for out-of-window accesses.
// Ack at t+2+RD_LAT for in-window reads, t+2 for in-window writes, t+1 out of window.
// Masters hold req until a one-clock ack. The RAM port takes a strobe every clock, so it never stalls.
module cc3_mem_arbiter
  import cc3_bus_pkg::*;
#(
  parameter int          MEM_AW   = CC3_MEM_AW,
  parameter logic [15:0] WIN_BASE = CC3_WIN_BASE,
  parameter int          RD_LAT   = 1,
  parameter logic [7:0]  OPEN_BUS = CC3_OPEN_BUS
) (
  input  logic              clk40_i,
  input  logic              rst_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [15:0]       m0_addr_i,
  input  logic [7:0]        m0_data_i,
  output logic [7:0]        m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [15:0]       m1_addr_i,
  input  logic [7:0]        m1_data_i,
  output logic [7:0]        m1_data_o,
  output logic              m1_ack_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              mem_we_o,
  output logic              mem_ce_o,
  input  logic [7:0]        mem_data_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  arb_state_t        state;
  logic              last_grant;
  logic [1:0]        lat_cnt;
  logic [1:0]        pick;
  logic [15:0]       sel_addr;
  logic              sel_we;
  logic [7:0]        sel_data;
  logic [MEM_AW-1:0] sel_offs;

  cc3_rr_arb2 u_arb (
    .req        ({m1_req_i, m0_req_i}),
    .last_grant (last_grant),
    .advance    (state == ST_IDLE),
    .grant      (pick)
  );

  assign sel_addr = pick[1] ? m1_addr_i : m0_addr_i;
  assign sel_we   = pick[1] ? m1_we_i   : m0_we_i;
  assign sel_data = pick[1] ? m1_data_i : m0_data_i;
  assign sel_offs = sel_addr[MEM_AW-1:0] - WIN_BASE[MEM_AW-1:0];

  // mem_addr/data/we hold the latched transaction; mem_we_o doubles as the latched direction.
  always_ff @(posedge clk40_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      lat_cnt    <= 2'd0;
      grant_o    <= 2'b00;
      busy_o     <= 1'b0;
      mem_ce_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= 8'h00;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_data_o  <= 8'h00;
      m1_data_o  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick != 2'b00) begin
            grant_o    <= pick;
            last_grant <= pick[1];
            busy_o     <= 1'b1;
            if (in_window(sel_addr, WIN_BASE, MEM_AW)) begin
              mem_ce_o   <= 1'b1;
              mem_addr_o <= sel_offs;
              mem_we_o   <= sel_we;
              mem_data_o <= sel_data;
              state      <= ST_ISSUE;
            end else begin
              // Out-of-window: writes vanish, reads see the floating bus.
              state    <= ST_ACK;
              m0_ack_o <= pick[0];
              m1_ack_o <= pick[1];
              if (pick[0] && !sel_we) m0_data_o <= OPEN_BUS;
              if (pick[1] && !sel_we) m1_data_o <= OPEN_BUS;
            end
          end
        end
        ST_ISSUE: begin
          mem_ce_o <= 1'b0;
          if (mem_we_o) begin
            state    <= ST_ACK;
            m0_ack_o <= grant_o[0];
            m1_ack_o <= grant_o[1];
          end else begin
            state   <= ST_WAIT;
            lat_cnt <= 2'(RD_LAT - 1);
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state    <= ST_ACK;
            m0_ack_o <= grant_o[0];
            m1_ack_o <= grant_o[1];
            if (grant_o[0]) m0_data_o <= mem_data_i;
            if (grant_o[1]) m1_data_o <= mem_data_i;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        ST_ACK: begin
          m0_ack_o <= 1'b0;
          m1_ack_o <= 1'b0;
          grant_o  <= 2'b00;
          busy_o   <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cc3_mem_arbiter.sv
// Scoreboard bench for cc3_mem_arbiter: a main instance with RD_LAT=1 and a second with RD_LAT=3.
module tb_cc3_mem_arbiter;

  typedef struct {
    bit         m;
    bit         rd;
    logic [7:0] d;
    int         at_edge;
  } ack_t;

  typedef struct {
    logic [10:0] a;
    bit          we;
    logic [7:0]  d;
    int          at_edge;
  } mem_t;

  logic clk40 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk40 = ~clk40;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [7:0]  m0_wdat = 0, m1_wdat = 0;
  logic [7:0]  m0_rdat, m1_rdat, mem_wdat, mem_rdat;
  logic        m0_ack, m1_ack, mem_we, mem_ce, busy;
  logic [10:0] mem_addr;
  logic [1:0]  grant;

  logic        b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
  logic [15:0] b_m0_addr = 0, b_m1_addr = 0;
  logic [7:0]  b_m0_wdat = 0, b_m1_wdat = 0;
  logic [7:0]  b_m0_rdat, b_m1_rdat, b_mem_wdat, b_mem_rdat;
  logic        b_m0_ack, b_m1_ack, b_mem_we, b_mem_ce, b_busy;
  logic [10:0] b_mem_addr;
  logic [1:0]  b_grant;

  cc3_mem_arbiter #(.RD_LAT(1)) dut (
    .clk40_i(clk40), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
    .m0_data_o(m0_rdat), .m0_ack_o(m0_ack),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
    .m1_data_o(m1_rdat), .m1_ack_o(m1_ack),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdat), .mem_we_o(mem_we), .mem_ce_o(mem_ce),
    .mem_data_i(mem_rdat), .grant_o(grant), .busy_o(busy)
  );

  cc3_mem_arbiter #(.RD_LAT(3)) dut_b (
    .clk40_i(clk40), .rst_n_i(rst_n),
    .m0_req_i(b_m0_req), .m0_we_i(b_m0_we), .m0_addr_i(b_m0_addr), .m0_data_i(b_m0_wdat),
    .m0_data_o(b_m0_rdat), .m0_ack_o(b_m0_ack),
    .m1_req_i(b_m1_req), .m1_we_i(b_m1_we), .m1_addr_i(b_m1_addr), .m1_data_i(b_m1_wdat),
    .m1_data_o(b_m1_rdat), .m1_ack_o(b_m1_ack),
    .mem_addr_o(b_mem_addr), .mem_data_o(b_mem_wdat), .mem_we_o(b_mem_we), .mem_ce_o(b_mem_ce),
    .mem_data_i(b_mem_rdat), .grant_o(b_grant), .busy_o(b_busy)
  );

  // RAM models: read data is valid only in its one latency slot, 8'hEE otherwise.
  logic [7:0] ram_a [0:2047];
  logic [7:0] ram_b [0:2047];
  logic [7:0] b_s1 = 8'hEE, b_s2 = 8'hEE, b_s3 = 8'hEE;
  logic [7:0] a_rd = 8'hEE;
  assign mem_rdat   = a_rd;
  assign b_mem_rdat = b_s3;

  always @(posedge clk40) begin
    if (mem_ce) begin
      if (mem_we) ram_a[mem_addr] <= mem_wdat;
      a_rd <= mem_we ? 8'hEE : ram_a[mem_addr];
    end else begin
      a_rd <= 8'hEE;
    end
    b_s1 <= (b_mem_ce && !b_mem_we) ? ram_b[b_mem_addr] : 8'hEE;
    b_s2 <= b_s1;
    b_s3 <= b_s2;
  end

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] sh0 = 8'h00, sh1 = 8'h00;
  ack_t ack_q[$];
  mem_t mem_q[$];
  ack_t ae;
  mem_t me;
  int   t_b;
  bit   got_b;
  int   nacks;

  always @(posedge clk40) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: anything seen here at edge cyc+1 must match the head of its queue.
  always @(negedge clk40) begin
    if (rst_n) begin
      if (m0_ack || m1_ack) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 32'({m1_ack, m0_ack}), 32'd0);
        end else begin
          ae = ack_q.pop_front();
          check("ack_master", 32'({m1_ack, m0_ack}), 32'(ae.m ? 2'b10 : 2'b01));
          check("ack_grant", 32'(grant), 32'(ae.m ? 2'b10 : 2'b01));
          if (ae.at_edge >= 0) check("ack_edge", 32'(cyc + 1), 32'(ae.at_edge));
          if (!ae.m) begin
            if (ae.rd) sh0 = ae.d;
          end else begin
            if (ae.rd) sh1 = ae.d;
          end
          check("m0_data", 32'(m0_rdat), 32'(sh0));
          check("m1_data", 32'(m1_rdat), 32'(sh1));
        end
      end
      if (mem_ce) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_ce", 32'(mem_addr), 32'hFFFF);
        end else begin
          me = mem_q.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(me.a));
          check("mem_we", 32'(mem_we), 32'(me.we));
          if (me.we) check("mem_wdata", 32'(mem_wdat), 32'(me.d));
          if (me.at_edge >= 0) check("mem_edge", 32'(cyc + 1), 32'(me.at_edge));
        end
      end
    end
  end

  // Called one step after an edge with the DUT in IDLE; the next edge samples the request.
  task automatic txn(input bit m, input bit we, input logic [15:0] a,
                     input logic [7:0] d, input logic [7:0] rexp);
    int t;
    bit inw;
    bit got;
    t   = cyc + 1;
    inw = (a >= 16'hF800);
    if (inw) mem_q.push_back('{a: 11'(a - 16'hF800), we: we, d: d, at_edge: t + 1});
    ack_q.push_back('{m: m, rd: !we && 1'b1, d: rexp, at_edge: t + (!inw ? 1 : (we ? 2 : 3))});
    if (m) begin
      m1_req = 1; m1_we = we; m1_addr = a; m1_wdat = d;
    end else begin
      m0_req = 1; m0_we = we; m0_addr = a; m0_wdat = d;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk40);
      got = m ? m1_ack : m0_ack;
    end
    if (!got) check("txn_timeout", 32'd0, 32'd1);
    m0_req = 0;
    m1_req = 0;
    @(posedge clk40);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram_a[i] = 8'h00;
      ram_b[i] = 8'h00;
    end
    ram_a[11'h005] = 8'h5A;
    ram_a[11'h010] = 8'h77;
    ram_b[11'h005] = 8'h5A;

    // 1: reset held with both masters requesting
    m0_req = 1; m0_addr = 16'hF805; m1_req = 1; m1_addr = 16'hFFFF;
    repeat (3) begin
      @(negedge clk40);
      check("rst_mem_ce", 32'(mem_ce), 32'd0);
      check("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data", 32'({m1_rdat, m0_rdat}), 32'd0);
    end
    m0_req = 0; m1_req = 0;
    @(posedge clk40); #1;
    rst_n = 1;

    // 2: m0 in-window read
    txn(0, 0, 16'hF805, 8'h00, 8'h5A);
    // 3: m1 write to the top window byte, then read it back
    txn(1, 1, 16'hFFFF, 8'hC3, 8'h00);
    txn(1, 0, 16'hFFFF, 8'h00, 8'hC3);

    // 4: both request continuously; last served was m1, so m0 goes first
    for (int i = 0; i < 6; i++) begin
      ack_q.push_back('{m: i[0], rd: 1'b1, d: i[0] ? 8'hC3 : 8'h5A, at_edge: -1});
      mem_q.push_back('{a: i[0] ? 11'h7FF : 11'h005, we: 1'b0, d: 8'h00, at_edge: -1});
    end
    m0_we = 0; m0_addr = 16'hF805; m1_we = 0; m1_addr = 16'hFFFF;
    m0_req = 1; m1_req = 1;
    nacks = 0;
    for (int i = 0; i < 100 && nacks < 6; i++) begin
      @(negedge clk40);
      if (m0_ack || m1_ack) nacks++;
    end
    check("contention_acks", 32'(nacks), 32'd6);
    m0_req = 0; m1_req = 0;
    @(posedge clk40); #1;

    // 5: out-of-window read and write, then prove RAM byte 7FF kept its value
    txn(0, 0, 16'h1234, 8'h00, 8'hFF);
    txn(0, 1, 16'hF7FF, 8'h11, 8'h00);
    txn(1, 0, 16'hFFFF, 8'h00, 8'hC3);

    // 6: reset while an m1 read sits in WAIT
    t_b = cyc + 1;
    mem_q.push_back('{a: 11'h010, we: 1'b0, d: 8'h00, at_edge: t_b + 1});
    m1_we = 0; m1_addr = 16'hF810; m1_req = 1;
    @(posedge clk40); @(posedge clk40); #1;
    check("wait_busy", 32'(busy), 32'd1);
    m1_req = 0;
    rst_n = 0;
    @(posedge clk40); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ack", 32'(m1_ack), 32'd0);
    check("abort_m1_data", 32'(m1_rdat), 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_mem_ce", 32'(mem_ce), 32'd0);
    @(posedge clk40); #1;
    check("abort_ack2", 32'(m1_ack), 32'd0);
    rst_n = 1;
    sh0 = 8'h00; sh1 = 8'h00;

    // 6b: RD_LAT=3 instance, m0 read at F805 -> ack at t+5
    t_b = cyc + 1;
    b_m0_we = 0; b_m0_addr = 16'hF805; b_m0_req = 1;
    got_b = 0;
    for (int i = 0; i < 20 && !got_b; i++) begin
      @(negedge clk40);
      if (b_mem_ce) begin
        check("b_mem_addr", 32'(b_mem_addr), 32'h005);
        check("b_mem_edge", 32'(cyc + 1), 32'(t_b + 1));
      end
      if (b_m0_ack) begin
        got_b = 1;
        check("b_ack_edge", 32'(cyc + 1), 32'(t_b + 5));
        check("b_m0_data", 32'(b_m0_rdat), 32'h5A);
      end
    end
    if (!got_b) check("b_timeout", 32'd0, 32'd1);
    b_m0_req = 0;
    repeat (4) @(posedge clk40);
    #1;

    check("ack_q_empty", 32'(ack_q.size()), 32'd0);
    check("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
